// File: rtl/gpio_in_pkg.sv
// Shared register map and bus helpers for the gpio input port.
// Offsets match the gpio output peripheral and the software header.
package gpio_in_pkg;

    localparam logic [7:0] GPIO_DATA    = 8'h00;
    localparam logic [7:0] GPIO_RISE_EN = 8'h04;
    localparam logic [7:0] GPIO_FALL_EN = 8'h08;
    localparam logic [7:0] GPIO_STATUS  = 8'h0C;
    localparam logic [7:0] GPIO_IRQ_EN  = 8'h10;

    typedef enum logic [2:0] {
        REG_DATA,
        REG_RISE_EN,
        REG_FALL_EN,
        REG_STATUS,
        REG_IRQ_EN,
        REG_NONE
    } gpio_reg_e;

    // Word decode; the two byte-offset bits never select anything.
    function automatic gpio_reg_e reg_decode(input logic [7:0] addr);
        gpio_reg_e sel;
        case (addr[7:2])
            GPIO_DATA[7:2]:    sel = REG_DATA;
            GPIO_RISE_EN[7:2]: sel = REG_RISE_EN;
            GPIO_FALL_EN[7:2]: sel = REG_FALL_EN;
            GPIO_STATUS[7:2]:  sel = REG_STATUS;
            GPIO_IRQ_EN[7:2]:  sel = REG_IRQ_EN;
            default:           sel = REG_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_in_if.sv
// Register bus shared by the gpio peripherals: byte-addressed writes,
// registered read data one cycle after the address.
interface gpio_in_if;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] q;

    modport master (output addr, output be, output wdata, output we, input q);
    modport slave  (input addr, input be, input wdata, input we, output q);
endinterface

// File: rtl/gpio_in_debounce.sv
// One input pin: two-flop synchronizer followed by an optional
// consecutive-mismatch filter that only accepts changes held DEBOUNCE cycles.
module gpio_in_debounce #(
    parameter int DEBOUNCE = 0,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic stable
);

    logic sync1;
    logic sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

    generate
        if (DEBOUNCE == 0) begin : g_bypass
            assign stable = sync2;
        end else begin : g_filter
            localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE - 1);

            logic [CNT_W-1:0] cnt;
            logic             stable_q;

            // Any agreeing sample restarts the run, so short glitches never land.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt      <= '0;
                    stable_q <= 1'b0;
                end else if (sync2 == stable_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_TC) begin
                    stable_q <= sync2;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign stable = stable_q;
        end
    endgenerate

endmodule

// File: rtl/gpio_in.sv
// Bus-mapped GPIO input port: filtered pin value, edge capture into sticky
// W1C status flags, and a masked level interrupt.
module gpio_in
    import gpio_in_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int DEBOUNCE = 0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    gpio_in_if.slave         bus,
    output logic             irq,
    input  logic [WIDTH-1:0] pins
);

    gpio_reg_e        sel;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] status;
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] wen;
    logic [WIDTH-1:0] wbits;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      bmask;
    logic [31:0]      rd_data;
    logic [31:0]      q_r;
    logic             unused_bus;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_pin
            gpio_in_debounce #(
                .DEBOUNCE (DEBOUNCE),
                .CNT_W    (CNT_W)
            ) u_debounce (
                .clk    (clk),
                .rst    (rst),
                .pin    (pins[i]),
                .stable (stable[i])
            );
        end
    endgenerate

    assign sel        = reg_decode(bus.addr);
    assign bmask      = be_mask(bus.be);
    assign wen        = bmask[WIDTH-1:0];
    assign wbits      = bus.wdata[WIDTH-1:0] & wen;
    assign w1c        = (bus.we && sel == REG_STATUS) ? wbits : '0;
    assign edge_hit   = (stable & ~prev & rise_en) | (~stable & prev & fall_en);
    assign unused_bus = ^{bus.wdata, bmask};

    always_comb begin
        rd_data = '0;
        case (sel)
            REG_DATA:    rd_data = 32'(stable);
            REG_RISE_EN: rd_data = 32'(rise_en);
            REG_FALL_EN: rd_data = 32'(fall_en);
            REG_STATUS:  rd_data = 32'(status);
            REG_IRQ_EN:  rd_data = 32'(irq_en);
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev    <= '0;
            evt     <= '0;
            rise_en <= '0;
            fall_en <= '0;
            status  <= '0;
            irq_en  <= '0;
            irq     <= 1'b0;
            q_r     <= '0;
        end else begin
            prev <= stable;
            // Edge flags are staged one cycle, so an enable written on the
            // detecting edge only affects later edges.
            evt  <= edge_hit;
            if (bus.we && sel == REG_RISE_EN) rise_en <= (rise_en & ~wen) | wbits;
            if (bus.we && sel == REG_FALL_EN) fall_en <= (fall_en & ~wen) | wbits;
            if (bus.we && sel == REG_IRQ_EN)  irq_en  <= (irq_en & ~wen) | wbits;
            // Set is applied after the clear: a coincident detect survives W1C.
            status <= (status & ~w1c) | evt;
            irq    <= |(status & irq_en);
            q_r    <= rd_data;
        end
    end

    assign bus.q = q_r;

endmodule

// File: tb/tb_gpio_in.sv
// Self-checking bench for gpio_in: directed register/edge/debounce sequences
// on two instances plus a randomized run against a latency-based model.
module tb_gpio_in;

    logic       clk;
    logic       rst;
    logic [3:0] pins0;
    logic [3:0] pins1;
    logic       irq0;
    logic       irq1;

    gpio_in_if bus0 ();
    gpio_in_if bus1 ();

    gpio_in #(.WIDTH(4), .DEBOUNCE(0), .CNT_W(8)) dut0 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus0),
        .irq  (irq0),
        .pins (pins0)
    );

    gpio_in #(.WIDTH(4), .DEBOUNCE(4), .CNT_W(8)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus1),
        .irq  (irq1),
        .pins (pins1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[12];

    localparam int NR  = 500;
    localparam int OFF = 4;

    logic [3:0] ph  [NR+OFF];
    logic [3:0] sth [NR+OFF];
    logic [3:0] reh [NR+OFF];
    logic [3:0] feh [NR+OFF];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic bwr(input int d, input logic [7:0] a, input logic [3:0] be,
                       input logic [31:0] wd);
        if (d == 0) begin
            bus0.addr = a; bus0.be = be; bus0.wdata = wd; bus0.we = 1'b1;
        end else begin
            bus1.addr = a; bus1.be = be; bus1.wdata = wd; bus1.we = 1'b1;
        end
        tick();
        bus0.we = 1'b0;
        bus1.we = 1'b0;
    endtask

    task automatic brd(input int d, input logic [7:0] a, output logic [31:0] v);
        if (d == 0) bus0.addr = a;
        else        bus1.addr = a;
        tick();
        v = (d == 0) ? bus0.q : bus1.q;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        logic [31:0] acc;
        logic [3:0]  m_re, m_fe, m_st, m_ie, ev, p, m8, wv;
        logic [7:0]  a;
        logic [3:0]  be;
        logic [31:0] wd, exp_q;
        logic        we;

        tbl[0]  = '{8'h04, 4'b0010, 32'hFFFF_FFFF, 32'h0};
        tbl[1]  = '{8'h04, 4'b0001, 32'hFFFF_FFFF, 32'hF};
        tbl[2]  = '{8'h07, 4'b0001, 32'h0000_0000, 32'h0};
        tbl[3]  = '{8'h08, 4'b1111, 32'h0000_000A, 32'hA};
        tbl[4]  = '{8'h10, 4'b1110, 32'h0000_00FF, 32'h0};
        tbl[5]  = '{8'h10, 4'b0001, 32'h0000_0005, 32'h5};
        tbl[6]  = '{8'h14, 4'b1111, 32'hFFFF_FFFF, 32'h0};
        tbl[7]  = '{8'h00, 4'b1111, 32'hFFFF_FFFF, 32'h0};
        tbl[8]  = '{8'hFC, 4'b1111, 32'hFFFF_FFFF, 32'h0};
        tbl[9]  = '{8'h0C, 4'b1111, 32'hFFFF_FFFF, 32'h0};
        tbl[10] = '{8'h08, 4'b1111, 32'h0000_0000, 32'h0};
        tbl[11] = '{8'h10, 4'b1111, 32'h0000_0000, 32'h0};

        bus0.addr = '0; bus0.be = '0; bus0.wdata = '0; bus0.we = 1'b0;
        bus1.addr = '0; bus1.be = '0; bus1.wdata = '0; bus1.we = 1'b0;

        // Reset held with pins high
        rst = 1'b0; pins0 = 4'hF; pins1 = 4'hF;
        repeat (10) tick();
        chk("reset_q0", bus0.q, 32'h0);
        chk("reset_irq0", {31'b0, irq0}, 32'h0);
        chk("reset_q1", bus1.q, 32'h0);
        rst = 1'b1;
        bus0.addr = 8'h00;
        tick();                     // edge 0
        tick();                     // edge 1
        chk("data_edge1", bus0.q, 32'h0);
        tick();                     // edge 2
        chk("data_edge2", bus0.q, 32'hF);
        pins0 = 4'h0; pins1 = 4'h0;
        repeat (20) tick();

        // Register table: byte enables, RO and unmapped words
        for (int i = 0; i < 12; i++) begin
            bwr(0, tbl[i].addr, tbl[i].be, tbl[i].wdata);
            brd(0, tbl[i].addr, v);
            chk($sformatf("tbl[%0d]", i), v, tbl[i].exp);
        end
        chk("tbl_irq", {31'b0, irq0}, 32'h0);

        // Rising edge, interrupt, W1C
        bwr(0, 8'h04, 4'hF, 32'hF);
        bwr(0, 8'h10, 4'hF, 32'h1);
        bus0.addr = 8'h0C;
        pins0 = 4'b0001;
        tick();                     // edge 0
        repeat (3) tick();          // edges 1..3
        chk("rise_irq_edge3", {31'b0, irq0}, 32'h0);
        tick();                     // edge 4
        chk("rise_status", bus0.q, 32'h1);
        chk("rise_irq_edge4", {31'b0, irq0}, 32'h1);
        bwr(0, 8'h0C, 4'hF, 32'h1);
        brd(0, 8'h0C, v);
        chk("w1c_status", v, 32'h0);
        chk("w1c_irq", {31'b0, irq0}, 32'h0);

        // Detect coinciding with W1C of the same bit
        pins0 = 4'b0011;
        tick();                     // edge 0
        repeat (2) tick();          // edges 1,2
        bus0.addr = 8'h0C; bus0.be = 4'hF; bus0.wdata = 32'h2; bus0.we = 1'b1;
        tick();                     // edge 3: set and clear together
        bus0.we = 1'b0;
        tick();
        chk("set_wins", bus0.q, 32'h2);
        bwr(0, 8'h0C, 4'hF, 32'hF);
        brd(0, 8'h0C, v);
        chk("set_wins_clear", v, 32'h0);

        // Debounce on the DEBOUNCE=4 instance
        bwr(1, 8'h04, 4'hF, 32'hF);
        bus1.addr = 8'h00;
        pins1 = 4'b0100;
        repeat (3) tick();          // pulse sampled at edges 0..2
        pins1 = 4'b0000;
        acc = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            acc = acc | bus1.q;
        end
        chk("short_pulse_data", acc, 32'h0);
        brd(1, 8'h0C, v);
        chk("short_pulse_status", v, 32'h0);
        bus1.addr = 8'h00;
        pins1 = 4'b0100;
        repeat (6) tick();          // edges 0..5
        chk("long_pulse_edge5", bus1.q, 32'h0);
        pins1 = 4'b0000;
        tick();                     // edge 6
        chk("long_pulse_edge6", bus1.q, 32'h4);
        repeat (5) tick();          // edges 7..11
        chk("release_edge11", bus1.q, 32'h4);
        tick();                     // edge 12
        chk("release_edge12", bus1.q, 32'h0);
        brd(1, 8'h0C, v);
        chk("long_pulse_status", v, 32'h4);

        // Reset in the middle of a pending interrupt
        pins0 = 4'h0;
        repeat (6) tick();
        bwr(0, 8'h0C, 4'hF, 32'hF);
        bwr(0, 8'h10, 4'hF, 32'hF);
        pins0 = 4'hF;
        repeat (6) tick();
        brd(0, 8'h0C, v);
        chk("pre_reset_status", v, 32'hF);
        chk("pre_reset_irq", {31'b0, irq0}, 32'h1);
        pins0 = 4'h0;
        repeat (6) tick();
        rst = 1'b0;
        #2;
        chk("async_irq", {31'b0, irq0}, 32'h0);
        chk("async_q", bus0.q, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        bus0.addr = 8'h0C;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            acc = acc | bus0.q | {31'b0, irq0};
        end
        chk("post_reset_quiet", acc, 32'h0);

        // Randomized run against the latency model (DEBOUNCE=0 instance)
        for (int k = 0; k < OFF; k++) begin
            ph[k] = '0; sth[k] = '0; reh[k] = '0; feh[k] = '0;
        end
        m_re = '0; m_fe = '0; m_st = '0; m_ie = '0;
        p = '0;
        for (int k = OFF; k < NR + OFF; k++) begin
            if ($urandom_range(0, 2) == 0) p = 4'($urandom);
            case ($urandom_range(0, 6))
                0: a = 8'h00;
                1: a = 8'h04;
                2: a = 8'h08;
                3: a = 8'h0C;
                4: a = 8'h10;
                5: a = 8'h14;
                default: a = 8'($urandom);
            endcase
            a  = a | 8'($urandom_range(0, 3));
            we = ($urandom_range(0, 2) == 0);
            be = 4'($urandom);
            wd = $urandom;

            // DATA follows the pin one edge late; a DATA change seen
            // between edges k-3 and k-2 lands in STATUS at edge k using
            // the enables in force before edge k-1.
            ph[k]  = p;
            reh[k] = m_re;
            feh[k] = m_fe;
            sth[k] = ph[k-1];
            ev = (sth[k-2] & ~sth[k-3] & reh[k-1]) | (~sth[k-2] & sth[k-3] & feh[k-1]);
            case (a[7:2])
                6'd0:    exp_q = {28'b0, sth[k-1]};
                6'd1:    exp_q = {28'b0, m_re};
                6'd2:    exp_q = {28'b0, m_fe};
                6'd3:    exp_q = {28'b0, m_st};
                6'd4:    exp_q = {28'b0, m_ie};
                default: exp_q = 32'h0;
            endcase
            v  = {31'b0, |(m_st & m_ie)};
            m8 = be[0] ? 4'hF : 4'h0;
            wv = wd[3:0] & m8;
            if (we) begin
                case (a[7:2])
                    6'd1: m_re = (m_re & ~m8) | wv;
                    6'd2: m_fe = (m_fe & ~m8) | wv;
                    6'd3: m_st = m_st & ~wv;
                    6'd4: m_ie = (m_ie & ~m8) | wv;
                    default: ;
                endcase
            end
            m_st = m_st | ev;

            pins0 = p;
            bus0.addr = a; bus0.be = be; bus0.wdata = wd; bus0.we = we;
            tick();
            chk($sformatf("rand_q[%0d]", k), bus0.q, exp_q);
            chk($sformatf("rand_irq[%0d]", k), {31'b0, irq0}, v);
        end
        bus0.we = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
